// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button conditioner for the intersection controller.
// Each of the four raw buttons is synchronised, debounced, edge-detected
// and watched for a stuck contact. The press pulses feed two independent
// request latches, one per crossing axis (NS = BTN1|BTN3, EW = BTN0|BTN2).
// A request is held until the controller acknowledges it while serving
// that axis's crossing phase.
module ped_request_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STUCK_CYCLES    = 250000000,
  parameter int CNT_W           = 28
) (
  input  logic       CCLK,
  input  logic       reset_n,
  input  logic [3:0] BTN,
  input  logic       NS_ACK,
  input  logic       EW_ACK,
  output logic       NS_REQ,
  output logic       EW_REQ,
  output logic       NS_WAIT,
  output logic       EW_WAIT,
  output logic [3:0] BTN_DB,
  output logic [3:0] BTN_PRESS,
  output logic [3:0] BTN_STUCK
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_MAX  = CNT_W'(STUCK_CYCLES);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } req_state_t;

  // Counter increment that stops at a ceiling instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  logic [3:0]       r_sync [SYNC_STAGES];
  logic [3:0]       w_sync;
  logic [3:0]       r_db;
  logic [CNT_W-1:0] r_db_cnt [4];
  logic [3:0]       w_db_flip;
  logic [3:0]       w_rise;
  logic [3:0]       w_fall;
  logic [CNT_W-1:0] r_st_cnt [4];
  logic [3:0]       r_stuck;
  logic [3:0]       r_press;
  logic             w_ns_press;
  logic             w_ew_press;
  req_state_t       r_ns_state;
  req_state_t       r_ew_state;
  logic             r_ns_req;
  logic             r_ew_req;

  // ---- stage: metastability synchroniser ----
  // Shift each raw button through SYNC_STAGES flops.
  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= BTN;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // ---- stage: debounce ----
  // A level flips once the mismatch has persisted for DEBOUNCE_CYCLES edges.
  always_comb begin
    w_db_flip = '0;
    for (int i = 0; i < 4; i++) begin
      w_db_flip[i] = (w_sync[i] != r_db[i]) && (r_db_cnt[i] == DB_LAST);
    end
  end

  assign w_rise = w_db_flip & ~r_db;
  assign w_fall = w_db_flip &  r_db;

  // Mismatch run counters; any cycle of agreement restarts the count.
  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_db <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_db <= r_db ^ w_db_flip;
      for (int i = 0; i < 4; i++) begin
        if ((w_sync[i] == r_db[i]) || w_db_flip[i]) r_db_cnt[i] <= '0;
        else                                          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
      end
    end
  end

  // ---- stage: stuck detection and press pulse ----
  // Count how long each debounced level stays high; flag it at the ceiling
  // and clear both on the falling edge of the debounced level.
  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_stuck <= '0;
      for (int i = 0; i < 4; i++) r_st_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!r_db[i] || w_fall[i]) begin
          r_st_cnt[i] <= '0;
          r_stuck[i]  <= 1'b0;
        end else begin
          r_st_cnt[i] <= sat_inc(r_st_cnt[i], ST_MAX);
          if (sat_inc(r_st_cnt[i], ST_MAX) == ST_MAX) r_stuck[i] <= 1'b1;
        end
      end
    end
  end

  // One-cycle pulse coincident with the debounced rise; a stuck button
  // never produces a new pulse.
  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) r_press <= '0;
    else          r_press <= w_rise & ~r_stuck;
  end

  assign w_ns_press = r_press[1] | r_press[3];
  assign w_ew_press = r_press[0] | r_press[2];

  // ---- stage: request latches ----
  // NS request latch; acknowledge wins over a simultaneous press.
  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_ns_state <= S_IDLE;
      r_ns_req   <= 1'b0;
    end else begin
      case (r_ns_state)
        S_IDLE: begin
          if (!NS_ACK && w_ns_press) begin
            r_ns_state <= S_PENDING;
            r_ns_req   <= 1'b1;
          end
        end
        S_PENDING: begin
          if (NS_ACK) begin
            r_ns_state <= S_IDLE;
            r_ns_req   <= 1'b0;
          end
        end
        default: begin
          r_ns_state <= S_IDLE;
          r_ns_req   <= 1'b0;
        end
      endcase
    end
  end

  // EW request latch; acknowledge wins over a simultaneous press.
  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_ew_state <= S_IDLE;
      r_ew_req   <= 1'b0;
    end else begin
      case (r_ew_state)
        S_IDLE: begin
          if (!EW_ACK && w_ew_press) begin
            r_ew_state <= S_PENDING;
            r_ew_req   <= 1'b1;
          end
        end
        S_PENDING: begin
          if (EW_ACK) begin
            r_ew_state <= S_IDLE;
            r_ew_req   <= 1'b0;
          end
        end
        default: begin
          r_ew_state <= S_IDLE;
          r_ew_req   <= 1'b0;
        end
      endcase
    end
  end

  assign NS_REQ    = r_ns_req;
  assign EW_REQ    = r_ew_req;
  assign NS_WAIT   = r_ns_req;
  assign EW_WAIT   = r_ew_req;
  assign BTN_DB    = r_db;
  assign BTN_PRESS = r_press;
  assign BTN_STUCK = r_stuck;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Self-checking bench for ped_request_conditioner with short debounce and
// stuck windows. A behavioural model runs alongside every clock edge.
module tb_ped_request_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int STK  = 64;

  logic       CCLK;
  logic       reset_n;
  logic [3:0] btn;
  logic       ns_ack;
  logic       ew_ack;
  logic       NS_REQ, EW_REQ, NS_WAIT, EW_WAIT;
  logic [3:0] BTN_DB, BTN_PRESS, BTN_STUCK;

  int checks = 0;
  int errors = 0;

  ped_request_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .STUCK_CYCLES(STK), .CNT_W(8)
  ) dut (
    .CCLK(CCLK), .reset_n(reset_n), .BTN(btn), .NS_ACK(ns_ack), .EW_ACK(ew_ack),
    .NS_REQ(NS_REQ), .EW_REQ(EW_REQ), .NS_WAIT(NS_WAIT), .EW_WAIT(EW_WAIT),
    .BTN_DB(BTN_DB), .BTN_PRESS(BTN_PRESS), .BTN_STUCK(BTN_STUCK)
  );

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  // Behavioural model state: synchronised samples as a delay queue, run
  // lengths of disagreement, and time spent debounced-high.
  logic [3:0] m_sq[$];
  logic [3:0] m_db, m_press, m_stuck;
  logic       m_ns, m_ew;
  int         m_run [4];
  int         m_hi  [4];

  task automatic model_reset();
    m_sq.delete();
    m_db = '0; m_press = '0; m_stuck = '0; m_ns = 1'b0; m_ew = 1'b0;
    for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_hi[i] = 0; end
  endtask

  task automatic model_step();
    logic [3:0] s;
    logic [3:0] db_old;
    if (!reset_n) begin
      model_reset();
      return;
    end
    // requests react to the pulses visible before this edge
    m_ns = ns_ack ? 1'b0 : (m_ns | m_press[1] | m_press[3]);
    m_ew = ew_ack ? 1'b0 : (m_ew | m_press[0] | m_press[2]);
    m_sq.push_back(btn);
    if (m_sq.size() > SYNC) s = m_sq.pop_front();
    else                    s = 4'b0;
    db_old = m_db;
    for (int i = 0; i < 4; i++) begin
      if (s[i] != db_old[i]) m_run[i]++;
      else                   m_run[i] = 0;
      if (m_run[i] >= DEB) begin
        m_db[i]  = ~m_db[i];
        m_run[i] = 0;
      end
      if (!m_db[i])      m_hi[i] = 0;
      else if (db_old[i]) m_hi[i]++;
      m_stuck[i] = m_db[i] && (m_hi[i] >= STK);
      m_press[i] = m_db[i] && !db_old[i] && !m_stuck[i];
    end
  endtask

  function automatic logic [15:0] dut_outs();
    return {NS_REQ, EW_REQ, NS_WAIT, EW_WAIT, BTN_DB, BTN_PRESS, BTN_STUCK};
  endfunction

  function automatic logic [15:0] model_outs();
    return {m_ns, m_ew, m_ns, m_ew, m_db, m_press, m_stuck};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic cyc();
    @(posedge CCLK);
    model_step();
    @(negedge CCLK);
    chk("model", dut_outs(), model_outs());
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  typedef struct {
    logic [3:0] btn;
    logic       ns_ack;
    logic       ew_ack;
    int         cycles;
    logic [3:0] exp_db;
    logic       exp_ns;
    logic       exp_ew;
  } vec_t;

  vec_t tbl [15];
  int   presses;

  initial begin
    // acknowledge/priority/simultaneous-axis table, starting from idle
    tbl[0]  = '{4'b1000, 1'b1, 1'b0, 30, 4'b1000, 1'b0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 1'b0, 25, 4'b0000, 1'b0, 1'b0};
    tbl[2]  = '{4'b1000, 1'b0, 1'b0, 25, 4'b1000, 1'b1, 1'b0};
    tbl[3]  = '{4'b1000, 1'b1, 1'b0,  1, 4'b1000, 1'b0, 1'b0};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 25, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{4'b1100, 1'b0, 1'b0, 25, 4'b1100, 1'b1, 1'b1};
    tbl[6]  = '{4'b1100, 1'b0, 1'b1,  1, 4'b1100, 1'b1, 1'b0};
    tbl[7]  = '{4'b0000, 1'b0, 1'b0, 25, 4'b0000, 1'b1, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0,  1, 4'b0000, 1'b0, 1'b0};
    tbl[9]  = '{4'b0011, 1'b0, 1'b0, 25, 4'b0011, 1'b1, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 1'b1,  1, 4'b0011, 1'b0, 1'b0};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 25, 4'b0000, 1'b0, 1'b0};
    tbl[12] = '{4'b0101, 1'b0, 1'b0, 25, 4'b0101, 1'b0, 1'b1};
    tbl[13] = '{4'b0101, 1'b0, 1'b1,  1, 4'b0101, 1'b0, 1'b0};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 25, 4'b0000, 1'b0, 1'b0};

    // reset with every button pressed
    reset_n = 1'b0; btn = 4'hF; ns_ack = 1'b0; ew_ack = 1'b0;
    model_reset();
    #1 chk("reset_outs_async", {16'h0, dut_outs()}, 32'h0);
    run(5);
    chk("reset_outs_held", {16'h0, dut_outs()}, 32'h0);

    // release with buttons idle: nothing may move
    btn = 4'h0; reset_n = 1'b1;
    presses = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc();
      if (dut_outs() != 16'h0) presses++;
    end
    chk("idle_after_reset", presses, 0);

    // clean press on BTN1: exact latency of level, pulse and request
    btn = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 17) chk("clean_db_before", BTN_DB[1], 0);
      if (k == 18) chk("clean_db_press", {BTN_DB[1], BTN_PRESS[1], NS_REQ}, 3'b110);
      if (k == 19) chk("clean_req", {BTN_PRESS[1], NS_REQ, NS_WAIT, EW_REQ, EW_WAIT}, 5'b01100);
    end
    btn = 4'b0; ns_ack = 1'b1;
    cyc();
    chk("ns_ack_clears", {NS_REQ, NS_WAIT}, 2'b00);
    ns_ack = 1'b0;
    run(25);

    // bounce: 15 cycles high, 1 low, must never pass the filter
    presses = 0;
    for (int k = 0; k < 200; k++) begin
      btn = ((k % 16) != 15) ? 4'b0001 : 4'b0000;
      cyc();
      presses += int'(BTN_PRESS[0]);
    end
    chk("bounce_no_press", presses, 0);
    chk("bounce_no_db", BTN_DB[0], 0);
    btn = 4'b0001;
    presses = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      presses += int'(BTN_PRESS[0]);
    end
    chk("bounce_then_hold_press", presses, 1);
    chk("bounce_then_hold_req", {EW_REQ, NS_REQ}, 2'b10);
    btn = 4'b0; ew_ack = 1'b1;
    cyc();
    ew_ack = 1'b0;
    run(25);

    // table-driven acknowledge, priority and axis independence
    for (int v = 0; v < 15; v++) begin
      btn = tbl[v].btn; ns_ack = tbl[v].ns_ack; ew_ack = tbl[v].ew_ack;
      run(tbl[v].cycles);
      chk($sformatf("tbl%0d_db", v), BTN_DB, tbl[v].exp_db);
      chk($sformatf("tbl%0d_req", v), {NS_REQ, EW_REQ}, {tbl[v].exp_ns, tbl[v].exp_ew});
    end
    ns_ack = 1'b0; ew_ack = 1'b0; btn = 4'b0;

    // stuck button on BTN0
    btn = 4'b0001;
    for (int k = 1; k <= 85; k++) begin
      cyc();
      if (k == 19) chk("stuck_req_set", EW_REQ, 1);
      if (k == 81) chk("stuck_not_yet", BTN_STUCK[0], 0);
      if (k == 82) chk("stuck_set", BTN_STUCK[0], 1);
    end
    ew_ack = 1'b1;
    cyc();
    chk("stuck_ack_clears", EW_REQ, 0);
    ew_ack = 1'b0;
    presses = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      presses += int'(BTN_PRESS[0]) + int'(EW_REQ);
    end
    chk("stuck_masked", presses, 0);
    btn = 4'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 17) chk("stuck_before_fall", {BTN_DB[0], BTN_STUCK[0]}, 2'b11);
      if (k == 18) chk("stuck_clears_at_fall", {BTN_DB[0], BTN_STUCK[0]}, 2'b00);
    end
    btn = 4'b0001;
    run(25);
    chk("stuck_repress_req", EW_REQ, 1);
    btn = 4'b0; ew_ack = 1'b1;
    cyc();
    ew_ack = 1'b0;
    run(25);

    // randomized buttons and acknowledges against the model
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        int b;
        b = int'($urandom_range(0, 3));
        btn[b] = ~btn[b];
      end
      if ($urandom_range(0, 39) == 0) ns_ack = ~ns_ack;
      if ($urandom_range(0, 39) == 0) ew_ack = ~ew_ack;
      cyc();
    end

    // reset in the middle of a debounce with a request pending
    btn = 4'b0; ns_ack = 1'b0; ew_ack = 1'b0;
    run(40);
    btn = 4'b0010;
    run(25);
    btn = 4'b0;
    run(25);
    chk("pre_reset_req", NS_REQ, 1);
    btn = 4'b0100;
    run(10);
    #2 reset_n = 1'b0;
    model_reset();
    #1 chk("midreset_outs", {16'h0, dut_outs()}, 32'h0);
    run(2);
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 17) chk("after_reset_db_restart", BTN_DB[2], 0);
      if (k == 18) chk("after_reset_db_rise", {BTN_DB[2], BTN_PRESS[2]}, 2'b11);
      if (k == 19) chk("after_reset_req", {NS_REQ, EW_REQ}, 2'b01);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
